// File: rtl/vending_fsm_param.sv
// Parametrised vending-machine control FSM.
// Tracks credit-driven item availability, per-item stock with restock,
// an idle timeout in COIN, a return-button hold filter, and one-hot
// lowest-index dispense arbitration. The datapath owns the coin total and
// debits the item price when o_output_item pulses.
//
// Interface semantics: there is no valid/ready handshake in this block.
// i_input_coin, i_select_item and i_restock are single-cycle strobes that
// are sampled on every rising clk edge. o_output_item is a one-cycle
// one-hot pulse that the datapath must act on in the cycle it is high.
// o_return_req is a level that stays high until i_coin_total reaches 0.
module vending_fsm_param #(
  parameter int NUM_ITEMS = 4,
  parameter int NUM_COINS = 3,
  parameter int CNT_W     = 32,
  parameter logic [NUM_ITEMS*CNT_W-1:0] ITEM_PRICES =
    {32'd2000, 32'd1000, 32'd500, 32'd400},
  parameter int WAIT_CYCLES = 100,
  parameter int RETURN_HOLD = 3,
  parameter int STOCK_W     = 4,
  parameter int INIT_STOCK  = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_COINS-1:0] i_input_coin,
  input  logic [NUM_ITEMS-1:0] i_select_item,
  input  logic                 i_trigger_return,
  input  logic [CNT_W-1:0]     i_coin_total,
  input  logic                 i_restock,
  input  logic [NUM_ITEMS-1:0] i_restock_item,
  input  logic [STOCK_W-1:0]   i_restock_qty,
  output logic [1:0]           o_state,
  output logic [NUM_ITEMS-1:0] o_available_item,
  output logic [NUM_ITEMS-1:0] o_output_item,
  output logic [NUM_ITEMS-1:0] o_sold_out,
  output logic [CNT_W-1:0]     o_wait_time,
  output logic                 o_return_req
);

  // Wide enough to hold RETURN_HOLD, and never zero bits wide.
  localparam int RH_W = $clog2(RETURN_HOLD + 2);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_COIN     = 2'd1,
    S_DISPENSE = 2'd2,
    S_RETURN   = 2'd3
  } state_t;

  state_t                            state_q;
  logic [RH_W-1:0]                   ret_cnt_q;
  logic [CNT_W-1:0]                  wait_q;
  logic [NUM_ITEMS-1:0]              sel_q;
  logic [NUM_ITEMS-1:0]              avail_q;
  logic [NUM_ITEMS-1:0]              out_q;
  logic [NUM_ITEMS-1:0]              sold_q;
  logic [NUM_ITEMS-1:0][STOCK_W-1:0] stock_q;

  logic [NUM_ITEMS-1:0]              avail_d;
  logic [NUM_ITEMS-1:0][STOCK_W-1:0] stock_d;
  logic [NUM_ITEMS-1:0][STOCK_W:0]   add_w;
  logic [NUM_ITEMS-1:0][STOCK_W:0]   sum_w;
  logic [NUM_ITEMS-1:0]              cand;
  logic [NUM_ITEMS-1:0]              grant_vec;

  logic coin_evt;
  logic any_sel;
  logic armed;
  logic has_credit;
  logic wait_zero;

  assign coin_evt   = |i_input_coin;
  assign any_sel    = |i_select_item;
  assign armed      = (ret_cnt_q == RH_W'(RETURN_HOLD));
  assign has_credit = (i_coin_total != '0);
  assign wait_zero  = (wait_q == '0);

  // Availability from live credit and current stock; registered in the FSM block.
  always_comb begin
    avail_d = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      avail_d[i] = (i_coin_total >= ITEM_PRICES[i*CNT_W +: CNT_W]) &&
                   (stock_q[i] != '0);
    end
  end

  // Lowest-index grant among selected, available items; only live in DISPENSE.
  always_comb begin
    cand      = sel_q & avail_q;
    grant_vec = '0;
    if (state_q == S_DISPENSE) begin
      grant_vec = cand & (~cand + NUM_ITEMS'(1));
    end
  end

  // Next stock: add restock quantity, subtract the granted item, saturate at max.
  always_comb begin
    add_w   = '0;
    sum_w   = '0;
    stock_d = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      add_w[i]   = (i_restock && i_restock_item[i]) ? {1'b0, i_restock_qty} : '0;
      sum_w[i]   = {1'b0, stock_q[i]} + add_w[i] - {{STOCK_W{1'b0}}, grant_vec[i]};
      stock_d[i] = sum_w[i][STOCK_W] ? {STOCK_W{1'b1}} : sum_w[i][STOCK_W-1:0];
    end
  end

  // Control FSM with its return filter, wait counter, stock and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      ret_cnt_q <= '0;
      wait_q    <= CNT_W'(WAIT_CYCLES);
      sel_q     <= '0;
      avail_q   <= '0;
      out_q     <= '0;
      sold_q    <= {NUM_ITEMS{(INIT_STOCK == 0)}};
      for (int i = 0; i < NUM_ITEMS; i++) begin
        stock_q[i] <= STOCK_W'(INIT_STOCK);
      end
    end else begin
      // Return filter: count consecutive high cycles, saturate, clear on low.
      if (!i_trigger_return) begin
        ret_cnt_q <= '0;
      end else if (!armed) begin
        ret_cnt_q <= ret_cnt_q + RH_W'(1);
      end

      avail_q <= avail_d;
      stock_q <= stock_d;
      out_q   <= grant_vec;
      for (int i = 0; i < NUM_ITEMS; i++) begin
        sold_q[i] <= (stock_q[i] == '0);
      end

      case (state_q)
        S_IDLE: begin
          if (coin_evt) begin
            state_q <= S_COIN;
            wait_q  <= CNT_W'(WAIT_CYCLES);
          end else if (armed && has_credit) begin
            state_q <= S_RETURN;
          end
        end
        S_COIN: begin
          if (coin_evt) begin
            wait_q <= CNT_W'(WAIT_CYCLES);
          end else if (any_sel) begin
            state_q <= S_DISPENSE;
            sel_q   <= i_select_item;
          end else begin
            if (!wait_zero) begin
              wait_q <= wait_q - CNT_W'(1);
            end
            if ((armed && has_credit) || wait_zero) begin
              state_q <= S_RETURN;
            end
          end
        end
        S_DISPENSE: begin
          // One cycle only; a real dispense restarts the idle timeout.
          state_q <= S_COIN;
          if (|grant_vec) begin
            wait_q <= CNT_W'(WAIT_CYCLES);
          end
        end
        default: begin
          if (!has_credit) begin
            state_q <= S_IDLE;
            wait_q  <= CNT_W'(WAIT_CYCLES);
          end
        end
      endcase
    end
  end

  assign o_state          = state_q;
  assign o_available_item = avail_q;
  assign o_output_item    = out_q;
  assign o_sold_out       = sold_q;
  assign o_wait_time      = wait_q;
  assign o_return_req     = (state_q == S_RETURN);

endmodule

// File: tb/tb_vending_fsm_param.sv
// Directed bench for vending_fsm_param with hand-computed expectations.
module tb_vending_fsm_param;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  i_input_coin;
  logic [3:0]  i_select_item;
  logic        i_trigger_return;
  logic [31:0] i_coin_total;
  logic        i_restock;
  logic [3:0]  i_restock_item;
  logic [3:0]  i_restock_qty;
  logic [1:0]  o_state;
  logic [3:0]  o_available_item;
  logic [3:0]  o_output_item;
  logic [3:0]  o_sold_out;
  logic [31:0] o_wait_time;
  logic        o_return_req;

  int n_vec  = 0;
  int n_miss = 0;

  vending_fsm_param dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .i_input_coin     (i_input_coin),
    .i_select_item    (i_select_item),
    .i_trigger_return (i_trigger_return),
    .i_coin_total     (i_coin_total),
    .i_restock        (i_restock),
    .i_restock_item   (i_restock_item),
    .i_restock_qty    (i_restock_qty),
    .o_state          (o_state),
    .o_available_item (o_available_item),
    .o_output_item    (o_output_item),
    .o_sold_out       (o_sold_out),
    .o_wait_time      (o_wait_time),
    .o_return_req     (o_return_req)
  );

  // Clock
  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  initial begin
    reset_n          = 1'b0;
    i_input_coin     = '0;
    i_select_item    = '0;
    i_trigger_return = 1'b0;
    i_coin_total     = '0;
    i_restock        = 1'b0;
    i_restock_item   = '0;
    i_restock_qty    = '0;
    tick();
    tick();
    reset_n = 1'b1;

    // Reset state
    check_val("rst_state", 32'(o_state), 32'd0);
    check_val("rst_avail", 32'(o_available_item), 32'd0);
    check_val("rst_out", 32'(o_output_item), 32'd0);
    check_val("rst_ret", 32'(o_return_req), 32'd0);
    check_val("rst_sold", 32'(o_sold_out), 32'd0);
    check_val("rst_wait", o_wait_time, 32'd100);

    // 1: coin with 600 credit, then let the timeout run out
    i_coin_total = 32'd600;
    i_input_coin = 3'b001;
    tick();
    i_input_coin = '0;
    check_val("t1_state_coin", 32'(o_state), 32'd1);
    check_val("t1_avail", 32'(o_available_item), 32'b0011);
    check_val("t1_wait_load", o_wait_time, 32'd100);
    for (int k = 99; k >= 0; k--) begin
      tick();
      check_val("t1_wait_count", o_wait_time, 32'(k));
      check_val("t1_still_coin", 32'(o_state), 32'd1);
    end
    tick();
    check_val("t1_state_ret", 32'(o_state), 32'd3);
    check_val("t1_ret_req", 32'(o_return_req), 32'd1);
    check_val("t1_wait_sat", o_wait_time, 32'd0);
    i_coin_total = 32'd0;
    tick();
    check_val("t1_state_idle", 32'(o_state), 32'd0);
    check_val("t1_ret_clr", 32'(o_return_req), 32'd0);
    check_val("t1_wait_idle", o_wait_time, 32'd100);

    // 2: multi-hot select 1010 dispenses item 1 only
    i_coin_total = 32'd2500;
    i_input_coin = 3'b010;
    tick();
    i_input_coin = '0;
    check_val("t2_avail", 32'(o_available_item), 32'b1111);
    for (int k = 0; k < 5; k++) tick();
    check_val("t2_wait_pre", o_wait_time, 32'd95);
    i_select_item = 4'b1010;
    tick();
    i_select_item = '0;
    check_val("t2_state_disp", 32'(o_state), 32'd2);
    check_val("t2_no_early_pulse", 32'(o_output_item), 32'd0);
    check_val("t2_wait_hold", o_wait_time, 32'd95);
    tick();
    check_val("t2_pulse", 32'(o_output_item), 32'b0010);
    check_val("t2_state_back", 32'(o_state), 32'd1);
    check_val("t2_wait_reload", o_wait_time, 32'd100);
    check_val("t2_stock1", 32'(dut.stock_q[1]), 32'd3);
    tick();
    check_val("t2_pulse_end", 32'(o_output_item), 32'd0);

    // 3: drain item 3, fifth select is empty, then restock
    for (int k = 0; k < 4; k++) begin
      i_select_item = 4'b1000;
      tick();
      i_select_item = '0;
      check_val("t3_disp", 32'(o_state), 32'd2);
      tick();
      check_val("t3_pulse", 32'(o_output_item), 32'b1000);
    end
    tick();
    check_val("t3_sold", 32'(o_sold_out), 32'b1000);
    check_val("t3_avail", 32'(o_available_item), 32'b0111);
    i_select_item = 4'b1000;
    tick();
    i_select_item = '0;
    check_val("t3_empty_disp", 32'(o_state), 32'd2);
    tick();
    check_val("t3_no_pulse", 32'(o_output_item), 32'd0);
    check_val("t3_no_reload", o_wait_time, 32'd99);
    i_restock      = 1'b1;
    i_restock_item = 4'b1000;
    i_restock_qty  = 4'd2;
    tick();
    i_restock = 1'b0;
    check_val("t3_stock3", 32'(dut.stock_q[3]), 32'd2);
    tick();
    check_val("t3_avail_back", 32'(o_available_item), 32'b1111);
    check_val("t3_sold_clr", 32'(o_sold_out), 32'd0);

    // 4: return filter, 2-cycle hold ignored, 3-cycle hold arms
    i_coin_total = 32'd800;
    tick();
    check_val("t4_avail", 32'(o_available_item), 32'b0011);
    i_trigger_return = 1'b1;
    tick();
    tick();
    i_trigger_return = 1'b0;
    tick();
    tick();
    check_val("t4_short_hold", 32'(o_state), 32'd1);
    i_trigger_return = 1'b1;
    tick();
    tick();
    tick();
    i_trigger_return = 1'b0;
    tick();
    check_val("t4_armed_ret", 32'(o_state), 32'd3);
    check_val("t4_ret_req", 32'(o_return_req), 32'd1);
    i_coin_total = 32'd0;
    tick();
    check_val("t4_idle", 32'(o_state), 32'd0);

    // 5: coin beats select; restock saturates with a simultaneous dispense
    i_coin_total = 32'd2500;
    i_input_coin = 3'b100;
    tick();
    i_input_coin = '0;
    tick();
    tick();
    tick();
    check_val("t5_wait_pre", o_wait_time, 32'd97);
    i_input_coin  = 3'b001;
    i_select_item = 4'b0100;
    tick();
    i_input_coin  = '0;
    i_select_item = '0;
    check_val("t5_coin_wins", 32'(o_state), 32'd1);
    check_val("t5_wait_reload", o_wait_time, 32'd100);
    tick();
    check_val("t5_no_pulse", 32'(o_output_item), 32'd0);
    i_select_item = 4'b0001;
    tick();
    i_select_item  = '0;
    i_restock      = 1'b1;
    i_restock_item = 4'b0001;
    i_restock_qty  = 4'd15;
    tick();
    i_restock = 1'b0;
    check_val("t5_pulse0", 32'(o_output_item), 32'b0001);
    check_val("t5_stock_sat", 32'(dut.stock_q[0]), 32'd15);

    // 6: reset while in DISPENSE
    i_select_item = 4'b0010;
    tick();
    i_select_item = '0;
    check_val("t6_disp", 32'(o_state), 32'd2);
    reset_n = 1'b0;
    tick();
    check_val("t6_state", 32'(o_state), 32'd0);
    check_val("t6_no_pulse", 32'(o_output_item), 32'd0);
    check_val("t6_stock1", 32'(dut.stock_q[1]), 32'd4);
    check_val("t6_wait", o_wait_time, 32'd100);
    reset_n = 1'b1;
    tick();
    check_val("t6_no_late_pulse", 32'(o_output_item), 32'd0);
    check_val("t6_sold", 32'(o_sold_out), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/vending_fsm_param.md
Name: vending_fsm_param

Overview:
- Parametrised control FSM for the vending machine datapath.
- Generalises item and coin count and per-item prices.
- Adds an internal wait-timeout counter, a configurable return-button hold filter, per-item stock tracking with restock, and one-hot lowest-index dispense arbitration.
- Sits between the coin-input/select front end and the change/total datapath.
- The datapath owns coin_total and debits the item price when o_output_item pulses.

Parameters:
NUM_ITEMS, 4, number of items (one-hot select/output width)
NUM_COINS, 3, number of coin inputs
CNT_W, 32, width of coin total and price values
ITEM_PRICES, {2000,1000,500,400}, packed NUM_ITEMS x CNT_W prices; item 0 in LSBs
WAIT_CYCLES, 100, idle cycles in COIN state before auto-return
RETURN_HOLD, 3, consecutive cycles i_trigger_return must be high to arm a return
STOCK_W, 4, stock counter width per item
INIT_STOCK, 4, stock loaded into every item at reset (at most 2^STOCK_W-1)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  reset, synchronous, active-low
i_input_coin  in  NUM_COINS  coin-insert strobes; any bit high = coin event
i_select_item  in  NUM_ITEMS  item select request (may be multi-hot)
i_trigger_return  in  1  return button, level
i_coin_total  in  CNT_W  current credit from datapath
i_restock  in  1  restock strobe
i_restock_item  in  NUM_ITEMS  one-hot item to restock
i_restock_qty  in  STOCK_W  quantity to add
o_state  out  2  FSM state
o_available_item  out  NUM_ITEMS  purchasable items
o_output_item  out  NUM_ITEMS  one-cycle one-hot dispense pulse
o_sold_out  out  NUM_ITEMS  stock==0 per item
o_wait_time  out  CNT_W  remaining timeout cycles
o_return_req  out  1  datapath must return change

Behaviour:
- Reset values: o_state = IDLE (0); o_available_item, o_output_item, o_return_req = 0; o_sold_out = 0 unless INIT_STOCK==0; o_wait_time = WAIT_CYCLES; every stock counter = INIT_STOCK; return filter count = 0.
- Reset mid-dispense cancels the pulse and does not decrement stock.
- States: IDLE=0, COIN=1, DISPENSE=2, RETURN=3.
- Return filter: counter increments each cycle i_trigger_return is high and saturates at RETURN_HOLD. It clears to 0 whenever i_trigger_return is low. `armed` = (count==RETURN_HOLD).
- Transitions, priority top-down in each state:
  - IDLE: coin event -> COIN; else armed && i_coin_total!=0 -> RETURN; else stay.
  - COIN: coin event -> COIN; else any i_select_item -> DISPENSE (latch select into sel_q); else (armed && i_coin_total!=0) || o_wait_time==0 -> RETURN; else stay.
  - DISPENSE: always -> COIN after exactly one cycle.
  - RETURN: i_coin_total==0 -> IDLE; else stay. Coins and selects are ignored.
- Wait counter:
  - Reloads WAIT_CYCLES on any coin event and on a successful dispense.
  - Decrements by 1 each cycle in COIN with no coin event and no select; saturates at 0.
  - Reloads WAIT_CYCLES on entry to IDLE.
  - Holds in DISPENSE and RETURN.
- Availability (combinational, then registered; 1-cycle latency from i_coin_total/stock change): item i is available iff i_coin_total >= ITEM_PRICES[i] (unsigned, CNT_W bits) AND stock[i]!=0.
- Dispense:
  - In DISPENSE, grant = lowest set bit of (sel_q & available).
  - o_output_item <= one-hot grant at the edge leaving DISPENSE, high for exactly one cycle.
  - An empty grant produces no pulse, no stock change and no wait reload.
  - Select sampled at edge t -> DISPENSE at t+1 -> pulse at t+2.
  - Only one item is dispensed per select.
- Stock:
  - Granted item decrements by 1 on the same edge as the pulse.
  - Restock adds i_restock_qty to the selected item, saturating at 2^STOCK_W-1.
  - Restock and dispense on the same item and edge: result = sat(stock - 1 + qty).
  - Restock of a multi-hot i_restock_item applies to every set item.
- o_return_req = 1 iff o_state==RETURN.
- o_sold_out[i] registered = (stock[i]==0).

Test Plan:
1. Reset, coin event with i_coin_total=600, no further input -> o_state=1; o_available_item=4'b0011 one cycle after total update; o_wait_time counts 100..0 then o_state=3, o_return_req=1; total forced to 0 -> o_state=0.
2. Total=2500, i_select_item=4'b1010 for one cycle -> o_state=2 next cycle, then o_output_item=4'b0010 for one cycle, stock[1]=3, o_wait_time=100.
3. Total=2500, select item 3 five times (stock 4) -> four pulses of 4'b1000, then o_sold_out[3]=1, o_available_item[3]=0; fifth select gives DISPENSE with no pulse. Restock item 3 qty 2 -> o_available_item[3]=1 the next cycle.
4. In COIN with total 800, return held 2 cycles then released -> no RETURN; held 3 cycles -> o_state=3 the cycle after the third sampled high.
5. Coin event and select on the same cycle in COIN -> stays COIN, wait reloaded, no dispense. Restock qty 15 on stock 4 with a simultaneous dispense -> stock=15 (saturated).
6. Reset asserted in DISPENSE -> next cycle o_state=0, o_output_item=0, stock unchanged.
